// File: rtl/rs_dec_ingress_pkg.sv
// Shared types and defaults for the RS decoder ingress block.
// Holds the FSM state type, default parameter values and the channel-index width helper.
package rs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } rs_state_e;

    localparam int RS_DATA_WIDTH = 8;
    localparam int RS_CH_NUM     = 4;
    localparam int RS_CW_LEN     = 16;
    localparam int RS_FIFO_DEPTH = 32;

    // A single channel still needs one bit so out_ch never collapses to zero width.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rs_dec_ingress_if.sv
// Codeword output stream from the ingress block to the downstream RS decoder.
interface rs_dec_ingress_if import rs_pkg::*; #(
    parameter int DATA_WIDTH = RS_DATA_WIDTH,
    parameter int CH_W       = ch_idx_w(RS_CH_NUM)
);
    logic                  vld;
    logic                  rdy;
    logic [DATA_WIDTH-1:0] data;
    logic [CH_W-1:0]       ch;
    logic                  sof;
    logic                  eof;

    modport master (output vld, data, ch, sof, eof, input rdy);
    modport slave  (input vld, data, ch, sof, eof, output rdy);
endinterface

// File: rtl/rs_sync_fifo.sv
// Per-channel synchronous FIFO with show-ahead head register and occupancy count.
module rs_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW-1:0]         rd_ptr_next;
    logic [AW:0]           count_reg;
    logic [DATA_WIDTH-1:0] head_reg;

    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    assign dout        = head_reg;
    assign count       = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Registered read of the next head; a write landing on that slot is bypassed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_reg <= '0;
        end else if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= din;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rs_dec_ingress.sv
// Multi-channel ingress for an RS decoder: buffers words per channel and forwards
// whole codewords round-robin over a ready/valid stream.
module rs_dec_ingress import rs_pkg::*; #(
    parameter int DATA_WIDTH = RS_DATA_WIDTH,
    parameter int CH_NUM     = RS_CH_NUM,
    parameter int CW_LEN     = RS_CW_LEN,
    parameter int FIFO_DEPTH = RS_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         rs_ena,
    input  logic [CH_NUM-1:0]            rx_vld,
    input  logic [CH_NUM*DATA_WIDTH-1:0] rx_data,
    output logic [CH_NUM-1:0]            rx_ovf,
    output logic                         busy,
    rs_dec_ingress_if.master             out_bus
);
    localparam int CH_W  = ch_idx_w(CH_NUM);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int WC_W  = (CW_LEN > 1) ? $clog2(CW_LEN) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CWLEN_C = CNT_W'(CW_LEN);

    rs_state_e             state_reg;
    logic [CH_W-1:0]       ch_reg;
    logic [CH_W-1:0]       last_reg;
    logic [WC_W-1:0]       wcnt_reg;
    logic                  vld_reg;
    logic                  sof_reg;
    logic                  eof_reg;
    logic [CH_NUM-1:0]     ovf_reg;

    logic [CH_NUM-1:0]     push;
    logic [CH_NUM-1:0]     pop;
    logic [CH_NUM-1:0]     drop;
    logic [CH_NUM-1:0]     eligible;
    logic [DATA_WIDTH-1:0] head  [CH_NUM];
    logic [CNT_W-1:0]      count [CH_NUM];

    logic                  grant_vld;
    logic [CH_W-1:0]       grant_ch;
    int                    grant_idx;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign push[gi]     = rx_vld[gi] && rs_ena && (count[gi] < DEPTH_C);
            assign drop[gi]     = rx_vld[gi] && rs_ena && (count[gi] == DEPTH_C);
            assign pop[gi]      = vld_reg && out_bus.rdy && (ch_reg == CH_W'(gi));
            assign eligible[gi] = count[gi] >= CWLEN_C;

            rs_sync_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rstn  (rstn),
                .push  (push[gi]),
                .din   (rx_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .pop   (pop[gi]),
                .dout  (head[gi]),
                .count (count[gi])
            );
        end
    endgenerate

    // Scan offsets from farthest to nearest so the channel right after last grant wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        grant_idx = 0;
        for (int k = CH_NUM; k >= 1; k--) begin
            grant_idx = (int'(last_reg) + k) % CH_NUM;
            if (eligible[CH_W'(grant_idx)]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(grant_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_reg <= '0;
        end else begin
            ovf_reg <= ovf_reg | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
            ch_reg    <= '0;
            last_reg  <= CH_W'(CH_NUM - 1);
            wcnt_reg  <= '0;
            vld_reg   <= 1'b0;
            sof_reg   <= 1'b0;
            eof_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rs_ena && grant_vld) begin
                        state_reg <= XFER;
                        ch_reg    <= grant_ch;
                        wcnt_reg  <= '0;
                        vld_reg   <= 1'b1;
                        sof_reg   <= 1'b1;
                        eof_reg   <= (CW_LEN == 1);
                    end
                end
                XFER: begin
                    if (out_bus.rdy) begin
                        if (eof_reg) begin
                            state_reg <= IDLE;
                            last_reg  <= ch_reg;
                            vld_reg   <= 1'b0;
                            sof_reg   <= 1'b0;
                            eof_reg   <= 1'b0;
                        end else begin
                            wcnt_reg  <= wcnt_reg + 1'b1;
                            sof_reg   <= 1'b0;
                            eof_reg   <= (wcnt_reg == WC_W'(CW_LEN - 2));
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx_ovf       = ovf_reg;
    assign busy         = vld_reg;
    assign out_bus.vld  = vld_reg;
    assign out_bus.ch   = ch_reg;
    assign out_bus.sof  = sof_reg;
    assign out_bus.eof  = eof_reg;
    assign out_bus.data = vld_reg ? head[ch_reg] : '0;

endmodule

// File: tb/tb_rs_dec_ingress.sv
// Directed plus randomized bench for rs_dec_ingress against a queue-based codeword model.
module tb_rs_dec_ingress;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rs_ena;
    logic [3:0]  rx_vld;
    logic [31:0] rx_data;
    logic [3:0]  rx_ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rs_dec_ingress_if #(.DATA_WIDTH(8), .CH_W(2)) ob();

    rs_dec_ingress #(
        .DATA_WIDTH (8),
        .CH_NUM     (4),
        .CW_LEN     (16),
        .FIFO_DEPTH (32)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rs_ena  (rs_ena),
        .rx_vld  (rx_vld),
        .rx_data (rx_data),
        .rx_ovf  (rx_ovf),
        .busy    (busy),
        .out_bus (ob.master)
    );

    // Reference: one word queue per channel plus "which codeword is in flight, at which word".
    logic [7:0] mq [4][$];
    logic [3:0] m_ovf;
    bit         m_act;
    int         m_ch;
    int         m_idx;
    int         m_last;

    task automatic model_update();
        int sz [4];
        bit g;
        int gc;
        if (!rstn) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_ovf  = '0;
            m_act  = 1'b0;
            m_ch   = 0;
            m_idx  = 0;
            m_last = 3;
            return;
        end
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        g  = 1'b0;
        gc = 0;
        if (!m_act && rs_ena) begin
            for (int k = 1; k <= 4; k++) begin
                if (!g && sz[(m_last + k) % 4] >= 16) begin
                    g  = 1'b1;
                    gc = (m_last + k) % 4;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rx_vld[i] && rs_ena) begin
                if (sz[i] < 32) mq[i].push_back(rx_data[i*8 +: 8]);
                else            m_ovf[i] = 1'b1;
            end
        end
        if (m_act && ob.rdy) begin
            void'(mq[m_ch].pop_front());
            if (m_idx == 15) begin
                m_act  = 1'b0;
                m_last = m_ch;
            end else begin
                m_idx++;
            end
        end
        if (g) begin
            m_act = 1'b1;
            m_ch  = gc;
            m_idx = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_vld", 32'(ob.vld), 32'(m_act));
        chk("busy", 32'(busy), 32'(m_act));
        chk("rx_ovf", 32'(rx_ovf), 32'(m_ovf));
        if (m_act) begin
            chk("out_data", 32'(ob.data), 32'(mq[m_ch][0]));
            chk("out_ch", 32'(ob.ch), 32'(m_ch));
            chk("out_sof", 32'(ob.sof), 32'(m_idx == 0));
            chk("out_eof", 32'(ob.eof), 32'(m_idx == 15));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic write_rand(input logic [3:0] mask, input int n);
        for (int j = 0; j < n; j++) begin
            rx_vld  = mask;
            rx_data = $urandom;
            tick();
        end
        rx_vld = '0;
    endtask

    task automatic wait_word(input int w, input string tag);
        int b;
        b = 0;
        while (!(m_act && m_idx == w) && b < 200) begin
            tick();
            b++;
        end
        chk(tag, 32'(b < 200), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data"}, 32'(ob.data), 32'd0);
        chk({tag, "_ch"}, 32'(ob.ch), 32'd0);
        chk({tag, "_sof"}, 32'(ob.sof), 32'd0);
        chk({tag, "_eof"}, 32'(ob.eof), 32'd0);
        chk({tag, "_vld"}, 32'(ob.vld), 32'd0);
    endtask

    initial begin
        rstn    = 1'b0;
        rs_ena  = 1'b1;
        rx_vld  = '0;
        rx_data = '0;
        ob.rdy  = 1'b1;
        run(2);
        check_reset_state("reset");
        rstn = 1'b1;
        run(2);

        // Ch0 sequential words; out_vld must appear exactly two cycles after the last write.
        for (int j = 0; j < 16; j++) begin
            rx_vld  = 4'b0001;
            rx_data = {24'h0, 8'(j)};
            tick();
        end
        rx_vld = '0;
        chk("lat_pre", 32'(ob.vld), 32'd0);
        tick();
        chk("lat_vld", 32'(ob.vld), 32'd1);
        chk("lat_data", 32'(ob.data), 32'h00);
        chk("lat_sof", 32'(ob.sof), 32'd1);
        run(25);

        // Simultaneous completion on ch1/ch2, then ch1/ch3 contention.
        write_rand(4'b0110, 16);
        run(45);
        write_rand(4'b1010, 16);
        run(45);

        // Stalling downstream with a 1,0,0,1 ready pattern.
        write_rand(4'b0001, 16);
        for (int j = 0; j < 80; j++) begin
            ob.rdy = (j % 4 == 0) || (j % 4 == 3);
            tick();
        end
        ob.rdy = 1'b1;
        run(5);

        // Overflow: 33 writes with the decoder stalled.
        ob.rdy = 1'b0;
        write_rand(4'b0001, 33);
        chk("ovf_set", 32'(rx_ovf), 32'h1);
        run(5);
        chk("ovf_sticky", 32'(rx_ovf), 32'h1);
        ob.rdy = 1'b1;
        run(50);

        // rs_ena dropped mid-codeword with ch2 full.
        ob.rdy = 1'b0;
        write_rand(4'b0101, 16);
        write_rand(4'b0100, 16);
        ob.rdy = 1'b1;
        wait_word(5, "reach_w5");
        rs_ena = 1'b0;
        write_rand(4'b0100, 30);
        chk("ena_off_ovf", 32'(rx_ovf), 32'h1);
        rs_ena = 1'b1;
        run(80);

        // Randomized traffic.
        for (int j = 0; j < 600; j++) begin
            rx_vld  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rx_data = $urandom;
            ob.rdy  = ($urandom_range(0, 3) != 0);
            rs_ena  = ($urandom_range(0, 7) != 0);
            tick();
        end
        rx_vld = '0;
        rs_ena = 1'b1;
        ob.rdy = 1'b1;
        run(150);

        // Reset in the middle of a codeword, then a fresh codeword.
        write_rand(4'b0010, 16);
        wait_word(8, "reach_w8");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_reset_state("mid_rst");
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovf", 32'(rx_ovf), 32'd0);
        run(3);
        write_rand(4'b1000, 16);
        tick();
        chk("fresh_sof", 32'(ob.sof), 32'd1);
        chk("fresh_ch", 32'(ob.ch), 32'd3);
        run(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_dec_ingress.md
RS_DEC_INGRESS -- requirements
Module: rs_dec_ingress

Interface
REQ-001 Clocking and reset SHALL be: one clock, clk; reset rstn is synchronous and active-low.
REQ-002 Parameter DATA_WIDTH, 8, symbol/word width of rx and out data.
REQ-003 Parameter CH_NUM, 4, number of independent receive channels (2..16).
REQ-004 Parameter CW_LEN, 16, words per RS codeword forwarded atomically.
REQ-005 Parameter FIFO_DEPTH, 32, per-channel FIFO depth; power of two, >= CW_LEN.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 rs_ena  in  1  global enable; gates ingress writes and new grants.
REQ-009 rx_vld  in  CH_NUM  per-channel word valid.
REQ-010 rx_data  in  CH_NUM*DATA_WIDTH  per-channel word; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 rx_ovf  out  CH_NUM  sticky per-channel overflow flag.
REQ-012 out_vld  out  1  output word valid.
REQ-013 out_rdy  in  1  downstream decoder ready.
REQ-014 out_data  out  DATA_WIDTH  output word.
REQ-015 out_ch  out  max(1,$clog2(CH_NUM))  source channel of current codeword.
REQ-016 out_sof / out_eof  out  1 each  first / last word of codeword, qualified by out_vld.
REQ-017 busy  out  1  high while in XFER.

Function
REQ-018 Channel i SHALL push rx_data[i] when rx_vld[i] && rs_ena && count[i] < FIFO_DEPTH; a simultaneous pop does not free space for that push.
REQ-019 When rx_vld[i] && rs_ena && count[i] == FIFO_DEPTH, word SHALL be dropped and rx_ovf[i] set; cleared only by reset.
REQ-020 When rs_ena is low, rx_vld SHALL be ignored; no drop, no rx_ovf change; FIFO contents retained.
REQ-021 FSM states SHALL be IDLE and XFER only.
REQ-022 IDLE: if rs_ena and any count[i] >= CW_LEN, grant the first eligible channel searching from last_grant+1 modulo CH_NUM, load out_ch, clear word counter, go to XFER next cycle.
REQ-023 XFER: out_vld SHALL be 1; out_data SHALL be head of granted FIFO (show-ahead); transfer occurs on out_vld && out_rdy.
REQ-024 out_sof SHALL be 1 when word counter == 0; out_eof SHALL be 1 when word counter == CW_LEN-1.
REQ-025 While out_vld && !out_rdy, out_data, out_ch, out_sof, out_eof SHALL hold stable.
REQ-026 Transfer of the eof word SHALL update last_grant and return to IDLE; exactly one IDLE cycle separates consecutive codewords.
REQ-027 rs_ena falling during XFER SHALL NOT abort; the codeword completes, then no new grant until rs_ena high.
REQ-028 Latency: with FSM idle and no contention, out_vld SHALL assert exactly 2 cycles after the cycle the CW_LEN-th word is written.
REQ-029 Occupancy counters and pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-030 A channel receiving writes while granted SHALL push and pop in the same cycle; count unchanged.

Reset
REQ-031 On rstn low at a clock edge: FIFOs emptied, counts 0, rx_ovf 0, FSM IDLE, out_vld/out_sof/out_eof/busy 0, out_ch 0, out_data 0, last_grant CH_NUM-1.
REQ-032 Reset mid-XFER SHALL abandon the codeword; no partial codeword resumes after reset.

Structure
REQ-033 Shared package rs_pkg SHALL hold the FSM state typedef (IDLE, XFER), default parameter constants, and the channel-index width helper.
REQ-034 Per-channel storage SHALL be a sub-module rs_sync_fifo (show-ahead, count output), instantiated CH_NUM times.

Verification
REQ-035 Ch0 writes 0x00..0x0F, out_rdy=1 -> out_vld 2 cycles after 0x0F write; 16 words in order, sof on 0x00, eof on 0x0F, out_ch=0.
REQ-036 Ch1 and ch2 complete in same cycle -> ch1 codeword, one idle cycle, ch2 codeword; next ch1+ch3 contention -> ch3 first.
REQ-037 out_rdy pattern 1,0,0,1 repeating -> outputs stable during stalls, 16 transfers exactly, eof only on 16th.
REQ-038 Ch0 writes 33 words with out_rdy=0 -> 33rd dropped, rx_ovf=0001 sticky; first 32 delivered as two codewords once out_rdy=1.
REQ-039 rs_ena low at word 5 of transfer with ch2 full -> current codeword completes; no grant, ch2 writes ignored, rx_ovf unchanged until rs_ena high.
REQ-040 rstn low at word 8 of transfer -> next cycle out_vld=0, busy=0, rx_ovf=0; fresh 16-word write delivers from sof.
